// File: rtl/beat_shift_register_pkg.sv
// rtl/beat_shift_register_pkg.sv - shared defaults and helpers for beat_shift_register
package beat_shift_register_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to hold a beat count from 0 up to and including depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/beat_slot_reg.sv
// rtl/beat_slot_reg.sv - one beat slot: WIDTH-bit register with load enable and async active-low clear
module beat_slot_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Take the new beat only when loading; otherwise hold, so d_in is ignored while idle.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d_in;
    end
  end

  // Slot storage, cleared immediately when reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_out = data_q;

endmodule

// File: rtl/beat_shift_register.sv
// rtl/beat_shift_register.sv - DEPTH-beat shift register; BEAT_SHIFT_REGISTER_FULL_EN adds a saturating count and full flag
module beat_shift_register
  import beat_shift_register_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_en,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH*DEPTH-1:0] data_out
`ifdef BEAT_SHIFT_REGISTER_FULL_EN
  ,
  output logic                   full
`endif
);

  // Reject configurations that cannot form a shift chain.
  if (DEPTH < 2 || WIDTH < 1) begin : g_bad_params
    $error("beat_shift_register: DEPTH must be >= 2 and WIDTH >= 1");
  end

  // Slot k loads from slot k-1; slot 0 loads from data_in.
  logic [WIDTH*DEPTH-1:0] chain_in;
  logic [WIDTH-1:0]       slot_out [DEPTH];

  assign chain_in = {data_out[WIDTH*(DEPTH-1)-1:0], data_in};

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    beat_slot_reg #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst),
      .load  (write_en),
      .d_in  (chain_in[k*WIDTH +: WIDTH]),
      .q_out (slot_out[k])
    );
    assign data_out[k*WIDTH +: WIDTH] = slot_out[k];
  end

`ifdef BEAT_SHIFT_REGISTER_FULL_EN
  localparam int             CW        = count_width(DEPTH);
  localparam logic [CW-1:0]  COUNT_MAX = CW'(DEPTH);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;
  logic          full_d;
  logic          full_q;

  // Count accepted beats, saturating once every slot has been filled.
  always_comb begin
    count_d = count_q;
    if (write_en && (count_q != COUNT_MAX)) begin
      count_d = count_q + CW'(1);
    end
    full_d = (count_d == COUNT_MAX);
  end

  // Counter and full flag registers, cleared with the slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign full = full_q;
`endif

endmodule

// File: tb/tb_beat_shift_register.sv
// tb/tb_beat_shift_register.sv - scoreboard bench for beat_shift_register (DEPTH=4, WIDTH=4)
module tb_beat_shift_register;

  logic        clk;
  logic        rst;
  logic        write_en;
  logic [3:0]  data_in;
  logic [15:0] data_out;
`ifdef BEAT_SHIFT_REGISTER_FULL_EN
  logic        full;
`endif

  beat_shift_register #(
    .DEPTH (4),
    .WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out)
`ifdef BEAT_SHIFT_REGISTER_FULL_EN
    ,
    .full     (full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        full;
    time         due;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic push_exp(input logic [15:0] d, input logic f, input time due, input string nm);
    exp_t e;
    e.data = d;
    e.full = f;
    e.due  = due;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge; the result is due at the next falling edge.
  task automatic do_cycle(input logic we, input logic [3:0] d, input logic [15:0] exp,
                          input logic expf, input string nm);
    write_en = we;
    data_in  = d;
    push_exp(exp, expf, $time + 10, nm);
    @(negedge clk);
  endtask

  // Monitor: compare every expectation once its due time has arrived.
  initial begin
    forever begin
      #1;
      while (exp_q.size() > 0 && exp_q[0].due <= $time) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (data_out !== mon_e.data) begin
          errors++;
          $display("FAIL %s data_out got %h expected %h at %0t", mon_e.name, data_out, mon_e.data, $time);
        end
`ifdef BEAT_SHIFT_REGISTER_FULL_EN
        checks++;
        if (full !== mon_e.full) begin
          errors++;
          $display("FAIL %s full got %b expected %b at %0t", mon_e.name, full, mon_e.full, $time);
        end
`endif
      end
    end
  end

  initial begin
    rst      = 1'b0;
    write_en = 1'b1;
    data_in  = 4'h5;
    push_exp(16'h0000, 1'b0, 2, "reset_state");
    @(negedge clk);
    push_exp(16'h0000, 1'b0, $time, "no_shift_in_reset");
    rst = 1'b1;

    do_cycle(1'b1, 4'h1, 16'h0001, 1'b0, "w1");
    do_cycle(1'b1, 4'h2, 16'h0012, 1'b0, "w2");
    do_cycle(1'b1, 4'h3, 16'h0123, 1'b0, "w3");
    do_cycle(1'b1, 4'h4, 16'h1234, 1'b1, "w4_full");
    do_cycle(1'b1, 4'h5, 16'h2345, 1'b1, "ovf5");
    do_cycle(1'b1, 4'h6, 16'h3456, 1'b1, "ovf6");
    do_cycle(1'b1, 4'h7, 16'h4567, 1'b1, "ovf7");
    do_cycle(1'b1, 4'h8, 16'h5678, 1'b1, "ovf8");
    do_cycle(1'b0, 4'hx, 16'h5678, 1'b1, "idle_x");
    do_cycle(1'b0, 4'h9, 16'h5678, 1'b1, "idle_9");
    do_cycle(1'b0, 4'hF, 16'h5678, 1'b1, "idle_f");
    do_cycle(1'b1, 4'hA, 16'h678A, 1'b1, "wA");
    do_cycle(1'b1, 4'hB, 16'h78AB, 1'b1, "wB");

    #2;
    rst      = 1'b0;
    write_en = 1'b1;
    data_in  = 4'hC;
    push_exp(16'h0000, 1'b0, $time + 2, "rst_async");
    @(negedge clk);
    push_exp(16'h0000, 1'b0, $time, "rst_hold_no_shift");
    rst = 1'b1;

    do_cycle(1'b1, 4'h1, 16'h0001, 1'b0, "rw1");
    do_cycle(1'b1, 4'h2, 16'h0012, 1'b0, "rw2");
    do_cycle(1'b1, 4'h3, 16'h0123, 1'b0, "rw3");
    do_cycle(1'b1, 4'h4, 16'h1234, 1'b1, "rw4_full");
    do_cycle(1'b0, 4'h0, 16'h1234, 1'b1, "final_hold");

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      #1;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/beat_shift_register.md
BEAT_SHIFT_REGISTER -- requirements
Module: beat_shift_register

Interface
REQ-001 Parameter DEPTH SHALL default to 4 and set the number of beats held; legal range is 2 or more.
REQ-002 Parameter WIDTH SHALL default to 4 and set the bits per beat; legal range is 1 or more.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock, with all state updating on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: reset, asynchronous and active-low.
REQ-005 Port write_en SHALL be an input, 1 bit wide: beat-accept strobe, sampled on the rising edge of clk.
REQ-006 Port data_in SHALL be an input, WIDTH bits wide: the incoming beat.
REQ-007 Port data_out SHALL be an output, WIDTH*DEPTH bits wide: all held beats, concatenated.
REQ-008 Port full SHALL be an output, 1 bit wide, and SHALL exist only when BEAT_SHIFT_REGISTER_FULL_EN is defined.

Function
REQ-009 The block SHALL hold DEPTH beat slots, numbered 0 to DEPTH-1.
- Slot k drives data_out[k*WIDTH +: WIDTH].
- Slot 0 holds the newest beat; slot DEPTH-1 holds the oldest beat.
REQ-010 On a rising clk edge with rst high and write_en=1, the block SHALL perform a shift:
- slot 0 <= data_in;
- slot k <= slot k-1, for k = 1 .. DEPTH-1;
- the old contents of slot DEPTH-1 are discarded.
REQ-011 On a rising clk edge with write_en=0, all slots SHALL hold their values.
REQ-012 data_out SHALL come directly from registers, with no combinational path from data_in or write_en.
- Write latency: a beat appears in slot 0 on the edge that accepts it.
REQ-013 Writing when all DEPTH slots are occupied SHALL be legal.
- The shift still occurs and the oldest beat is dropped; there is no back-pressure and no error signal.
REQ-014 An X or unknown value on data_in SHALL NOT affect state while write_en=0.

Reset
REQ-015 While rst=0, every slot SHALL be cleared to zero immediately, without waiting for a clk edge.
- data_out therefore reads 0.
REQ-016 While rst=0, the beat counter SHALL be cleared to 0 and full SHALL read 0 (when built in).
REQ-017 Reset asserted in the middle of a sequence of writes SHALL discard all held beats.
REQ-018 On the first rising clk edge after rst goes high, a write SHALL be accepted normally when write_en=1.

Configuration
REQ-019 With macro BEAT_SHIFT_REGISTER_FULL_EN defined, the block SHALL add a saturating beat counter of width $clog2(DEPTH+1).
- The counter increments on each accepted write until it reaches DEPTH, then stays at DEPTH.
- full is a registered output equal to (count == DEPTH).
REQ-020 Without BEAT_SHIFT_REGISTER_FULL_EN defined, the counter and the full port SHALL be absent.
- The data path behaviour is identical in both builds.

Structure
REQ-021 Package beat_shift_register_pkg SHALL hold:
- the default constants DEFAULT_DEPTH=4 and DEFAULT_WIDTH=4;
- a count-width helper function.
REQ-022 Each slot SHALL be one instance of the sub-module beat_slot_reg.
- beat_slot_reg is a WIDTH-bit register with asynchronous active-low clear and a load enable.
- Instances are chained by a generate loop.
REQ-023 An elaboration-time check SHALL flag an error for DEPTH<2 or WIDTH<1.

Verification (DEPTH=4, WIDTH=4)
REQ-024 Hold rst=0 for one cycle with write_en=1 and data_in=5 -> data_out=16'h0000 and no shift occurs.
REQ-025 Release rst, then write 1,2,3,4 on consecutive edges:
- data_out = 16'h0001, 16'h0012, 16'h0123, 16'h1234 after each edge;
- full rises together with 16'h1234.
REQ-026 Continue with writes 5,6,7,8 -> data_out = 16'h2345, 16'h3456, 16'h4567, 16'h5678 after each edge (overflow drops the oldest beat).
REQ-027 Drop write_en to 0 for 3 cycles while toggling data_in -> data_out stays 16'h5678.
REQ-028 Assert rst between clock edges after two writes -> data_out becomes 0 before the next edge, and full becomes 0.
REQ-029 Build without BEAT_SHIFT_REGISTER_FULL_EN and repeat REQ-025 -> identical data_out sequence, and no full port exists.
